// File: rtl/readout_rx_iq_window_integrator.sv
// readout_rx_iq_window_integrator: boxcar-integrates I/Q samples per window and
// frames a measurement of num_step windows with start/finish pulses.
module readout_rx_iq_window_integrator #(
    parameter int IN_WIDTH             = 16,
    parameter int DATA_WIDTH           = 16,
    parameter int WINDOW_COUNTER_WIDTH = 8,
    parameter int STEP_COUNTER_WIDTH   = 8,
    parameter int ACC_WIDTH            = 24,
    parameter int OUTPUT_SHIFT         = 3,
    parameter int DEFAULT_WINDOW_LEN   = 8,
    parameter int DEFAULT_NUM_STEP     = 125
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   window_len_wr_en,
    input  logic [WINDOW_COUNTER_WIDTH-1:0]        window_len_wr_data,
    input  logic                                   num_step_wr_en,
    input  logic [STEP_COUNTER_WIDTH-1:0]          num_step_wr_data,
    input  logic                                   meas_start,
    input  logic                                   abort,
    input  logic                                   valid_in,
    input  logic signed [IN_WIDTH-1:0]             i_in,
    input  logic signed [IN_WIDTH-1:0]             q_in,
    output logic                                   start_count,
    output logic                                   finish_count,
    output logic                                   valid_out,
    output logic signed [DATA_WIDTH-1:0]           i_out,
    output logic signed [DATA_WIDTH-1:0]           q_out,
    output logic                                   busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
    localparam int EXT = ACC_WIDTH - IN_WIDTH;
    localparam logic [WINDOW_COUNTER_WIDTH-1:0] W_ONE = WINDOW_COUNTER_WIDTH'(1);
    localparam logic [STEP_COUNTER_WIDTH-1:0] S_ONE = STEP_COUNTER_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_A = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_A = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    state_t state_q, state_d;
    logic [WINDOW_COUNTER_WIDTH-1:0] window_len_q, window_len_d, win_sh_q, win_sh_d, samp_cnt_q, samp_cnt_d;
    logic [STEP_COUNTER_WIDTH-1:0] num_step_q, num_step_d, step_sh_q, step_sh_d, step_cnt_q, step_cnt_d;
    logic signed [ACC_WIDTH-1:0] iacc_q, iacc_d, qacc_q, qacc_d, sum_i, sum_q;
    logic start_count_q, start_count_d, finish_count_q, finish_count_d, valid_out_q, valid_out_d;
    logic signed [DATA_WIDTH-1:0] i_out_q, i_out_d, q_out_q, q_out_d;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] s;
        s = v >>> OUTPUT_SHIFT;
        return (s > MAX_A) ? MAX_D : (s < MIN_A) ? MIN_D : s[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d        = state_q;
        window_len_d   = window_len_wr_en ? window_len_wr_data : window_len_q;
        num_step_d     = num_step_wr_en ? num_step_wr_data : num_step_q;
        win_sh_d       = win_sh_q;
        step_sh_d      = step_sh_q;
        samp_cnt_d     = samp_cnt_q;
        step_cnt_d     = step_cnt_q;
        iacc_d         = iacc_q;
        qacc_d         = qacc_q;
        start_count_d  = 1'b0;
        finish_count_d = 1'b0;
        valid_out_d    = 1'b0;
        i_out_d        = i_out_q;
        q_out_d        = q_out_q;
        sum_i          = iacc_q + $signed({{EXT{i_in[IN_WIDTH-1]}}, i_in});
        sum_q          = qacc_q + $signed({{EXT{q_in[IN_WIDTH-1]}}, q_in});
        case (state_q)
            IDLE: if (meas_start && !abort) begin
                state_d       = ACCUM;
                win_sh_d      = (window_len_q == '0) ? W_ONE : window_len_q;
                step_sh_d     = (num_step_q == '0) ? S_ONE : num_step_q;
                iacc_d        = '0;
                qacc_d        = '0;
                samp_cnt_d    = '0;
                step_cnt_d    = '0;
                start_count_d = 1'b1;
            end
            ACCUM: if (abort) begin
                state_d    = IDLE;
                iacc_d     = '0;
                qacc_d     = '0;
                samp_cnt_d = '0;
                step_cnt_d = '0;
            end else if (valid_in) begin
                if (samp_cnt_q == win_sh_q - W_ONE) begin
                    valid_out_d = 1'b1;
                    i_out_d     = sat(sum_i);
                    q_out_d     = sat(sum_q);
                    iacc_d      = '0;
                    qacc_d      = '0;
                    samp_cnt_d  = '0;
                    step_cnt_d  = step_cnt_q + S_ONE;
                    state_d     = (step_cnt_q == step_sh_q - S_ONE) ? FINISH : ACCUM;
                end else begin
                    iacc_d     = sum_i;
                    qacc_d     = sum_q;
                    samp_cnt_d = samp_cnt_q + W_ONE;
                end
            end
            // FINISH spans two cycles so finish_count lands after the last valid_out
            FINISH: if (abort || finish_count_q) begin
                state_d    = IDLE;
                step_cnt_d = '0;
            end else begin
                finish_count_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            window_len_q   <= WINDOW_COUNTER_WIDTH'(DEFAULT_WINDOW_LEN);
            num_step_q     <= STEP_COUNTER_WIDTH'(DEFAULT_NUM_STEP);
            win_sh_q       <= '0;
            step_sh_q      <= '0;
            samp_cnt_q     <= '0;
            step_cnt_q     <= '0;
            iacc_q         <= '0;
            qacc_q         <= '0;
            start_count_q  <= 1'b0;
            finish_count_q <= 1'b0;
            valid_out_q    <= 1'b0;
            i_out_q        <= '0;
            q_out_q        <= '0;
        end else begin
            state_q        <= state_d;
            window_len_q   <= window_len_d;
            num_step_q     <= num_step_d;
            win_sh_q       <= win_sh_d;
            step_sh_q      <= step_sh_d;
            samp_cnt_q     <= samp_cnt_d;
            step_cnt_q     <= step_cnt_d;
            iacc_q         <= iacc_d;
            qacc_q         <= qacc_d;
            start_count_q  <= start_count_d;
            finish_count_q <= finish_count_d;
            valid_out_q    <= valid_out_d;
            i_out_q        <= i_out_d;
            q_out_q        <= q_out_d;
        end
    end

    assign start_count  = start_count_q;
    assign finish_count = finish_count_q;
    assign valid_out    = valid_out_q;
    assign i_out        = i_out_q;
    assign q_out        = q_out_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: doc/readout_rx_iq_window_integrator.md
# readout_rx_iq_window_integrator

Upstream neighbour of the readout RX state-decision unit. Boxcar-integrates demodulated I/Q samples over a programmable window, emits one integrated I/Q point per window ("step"), and frames a measurement of a programmable number of steps with `start_count` / `finish_count` pulses. Its outputs drive the state-decision unit's `start_count`, `finish_count`, `valid_in`, `i_in` and `q_in` directly.

## Interface
- `IN_WIDTH`, 16: signed width of demodulated input samples.
- `DATA_WIDTH`, 16: signed width of the integrated outputs.
- `WINDOW_COUNTER_WIDTH`, 8: width of the window-length register and the sample counter.
- `STEP_COUNTER_WIDTH`, 8: width of the step-count register and the step counter.
- `ACC_WIDTH`, 24: accumulator width. Must be at least `IN_WIDTH` + `WINDOW_COUNTER_WIDTH`.
- `OUTPUT_SHIFT`, 3: arithmetic right shift applied to the accumulator before saturation.
- `DEFAULT_WINDOW_LEN`, 8: reset value of the window-length register.
- `DEFAULT_NUM_STEP`, 125: reset value of the step-count register.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `window_len_wr_en` in 1: write strobe for the window-length register.
- `window_len_wr_data` in `WINDOW_COUNTER_WIDTH`: samples per step.
- `num_step_wr_en` in 1: write strobe for the step-count register.
- `num_step_wr_data` in `STEP_COUNTER_WIDTH`: steps per measurement.
- `meas_start` in 1: pulse that starts a measurement.
- `abort` in 1: pulse that cancels the measurement in progress.
- `valid_in` in 1: input sample qualifier.
- `i_in`, `q_in` in `IN_WIDTH` (signed each): demodulated samples.
- `start_count` out 1: measurement-start pulse.
- `finish_count` out 1: measurement-end pulse.
- `valid_out` out 1: integrated-point qualifier.
- `i_out`, `q_out` out `DATA_WIDTH` (signed each): integrated point.
- `busy` out 1: high whenever the block is not in IDLE.

## Operation
- **Reset:** all outputs 0; state IDLE; accumulators and counters 0; config registers set to their DEFAULT values.
- **Config registers:** writable at any time. Their values are latched into shadow copies only when `meas_start` is accepted, so writes made while busy take effect at the next measurement. A value of 0 is treated as 1 for both registers.
- **IDLE:**
  - `meas_start` with no `abort` is accepted: shadows latched, I/Q accumulators cleared, sample and step counters cleared, state goes to ACCUM.
  - `start_count` = 1 in the following cycle only.
  - `valid_in` is ignored in IDLE.
- **ACCUM:**
  - Each cycle with `valid_in` = 1: acc_i += sign-extended `i_in`; acc_q += sign-extended `q_in`; the sample counter increments.
  - Cycles with `valid_in` = 0 hold all state; gaps are allowed.
  - The sample that brings the counter to the shadow window length (window-final sample) does the following:
    - registers out = sat((acc + sample) >>> `OUTPUT_SHIFT`), the saturation clamping to [-2^(`DATA_WIDTH`-1), 2^(`DATA_WIDTH`-1)-1];
    - `valid_out` = 1 for one cycle;
    - accumulators and sample counter reset to 0;
    - step counter increments.
  - The window-final sample of the last step (step counter = shadow num_step-1) moves the state to FINISH.
  - `meas_start` is ignored in ACCUM.
- **FINISH:** `finish_count` = 1 for one cycle, then the state returns to IDLE.
- **Abort (ACCUM or FINISH):**
  - The next state is IDLE; accumulators and counters are cleared.
  - No `valid_out` is issued for the partial window and no `finish_count` is issued.
  - Any `valid_out` already registered still appears.
  - `abort` in IDLE has no effect. `abort` and `meas_start` together: `abort` wins and the start is dropped.
- **Outputs between valid pulses:** `i_out` / `q_out` hold their last value; they are meaningful only while `valid_out` = 1.

## Timing
- Cycle t: `meas_start` sampled. Cycle t+1: `start_count` = 1 and `busy` = 1.
- A window-final sample sampled in cycle k produces `valid_out` in cycle k+1, so latency is 1 cycle.
- A new sample may be accepted in cycle k+1 into the next window, so throughput is 1 sample/cycle.
- Last `valid_out` in cycle m: `finish_count` in cycle m+1; `busy` = 0 from cycle m+2.
- Back-to-back measurements: the earliest accepted `meas_start` is in cycle m+2, giving the next `start_count` in cycle m+3.
- `start_count` always precedes the first `valid_out` by at least 1 cycle. `finish_count` never coincides with `valid_out`.

## Test plan
- **Basic framing:** window 4, steps 3, `OUTPUT_SHIFT` 2, i=100, q=-50 held, `valid_in` continuous.
  - `start_count` at t+1.
  - `valid_out` at t+5, t+9 and t+13, each carrying i_out=100, q_out=-50.
  - `finish_count` at t+14; `busy` low at t+15.
- **Input gaps:** same configuration with `valid_in` toggling 1,0,1,0.
  - Identical outputs, but `valid_out` spacing becomes 8 cycles.
  - Accumulated values are unaffected by the gaps.
- **Saturation:** window 16, `OUTPUT_SHIFT` 0, i=32767, q=-32768.
  - i_out=32767, q_out=-32768, no wrap.
- **Abort:** `abort` asserted after 2 samples of step 2.
  - No further `valid_out` and no `finish_count`; `busy` = 0 the next cycle.
  - A fresh measurement then starts from zeroed accumulators.
- **Config boundaries:**
  - window_len=0 behaves as window 1, giving `valid_out` every sample.
  - Writing num_step=5 while busy leaves the current measurement at 3 steps; the next measurement has 5 steps.
- **Reset and collisions:**
  - `rst` asserted mid-ACCUM clears all outputs immediately (asynchronous) and restores the DEFAULT config values.
  - `abort` together with `meas_start` in IDLE produces no `start_count`.
